apb_bridge_n: RTL and testbench

Parametrised APB master bridge that turns a simple valid/ready request port into APB SETUP/ACCESS transfers. It drives a bank of `NUM_SLV` peripherals, decoding the slave from the upper address bits. Over a fixed two-slave bridge it adds:
- configurable data/address width and slave count;
- per-slave PSLVERR capture;
- a wait-state timeout that aborts a hung transfer with an error;
- a registered one-cycle response strobe.

---
 rtl/apb_bridge_n.sv | 141 ++++++++++++++
 tb/tb_apb_bridge_n.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_n.sv
// apb_bridge_n: valid/ready request port to APB master bridge for a bank of
// NUM_SLV peripherals. The slave is decoded from the top address bits. The
// bridge captures the selected slave's PSLVERR, aborts hung transfers after
// a configurable number of wait states, and returns a one-cycle response strobe.
module apb_bridge_n #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int NUM_SLV = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SEL_W = $clog2(NUM_SLV);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Wait counter increment that sticks at all-ones instead of wrapping, so a
  // disabled timeout can never fire through a wrapped count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Read data returned to the requester: only a clean read carries data.
  function automatic logic [DATA_W-1:0] rsp_data_sel(input logic done,
                                                     input logic is_write,
                                                     input logic err,
                                                     input logic [DATA_W-1:0] rd);
    return (done && !is_write && !err) ? rd : '0;
  endfunction

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    wait_cnt;
  logic [SEL_W-1:0]    sel_idx;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                in_access;
  logic                accept;
  logic                xfer_done;
  logic                xfer_abort;
  logic [NUM_SLV-1:0]  sel_onehot;

  // The slave index is taken from the latched address, so no separate
  // select register is needed and PSEL stays consistent with PADDR.
  assign sel_idx    = PADDR[ADDR_W-1 -: SEL_W];
  assign sel_ready  = PREADY[sel_idx];
  assign sel_err    = PSLVERR[sel_idx];
  assign sel_rdata  = PRDATA[sel_idx*DATA_W +: DATA_W];
  assign in_access  = (state == ST_ACCESS);
  assign accept     = req_valid && req_ready;
  assign xfer_done  = in_access && sel_ready;
  // Ready in the limit cycle wins: abort only when the slave is still stalling.
  assign xfer_abort = in_access && !sel_ready && TO_EN && (wait_cnt == CNT_LIM);

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> SETUP -> ACCESS -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (xfer_done || xfer_abort) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only; req_ready has no path from req_valid.
  always_comb begin
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
    req_ready           = (state == ST_IDLE);
    PENABLE             = (state == ST_ACCESS);
    PSEL                = (state == ST_IDLE) ? '0 : sel_onehot;
  end

  // ---- request capture: APB address/data held until the next accept ----
  // Latch the request fields on accept; they hold through IDLE afterwards.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= req_write;
      PADDR  <= req_addr;
      PWDATA <= req_wdata;
    end
  end

  // Wait-state counter: zero outside ACCESS, counts stalled ACCESS cycles.
  always_ff @(posedge PCLK) begin
    if (PRESET || !in_access) wait_cnt <= '0;
    else if (!sel_ready)      wait_cnt <= sat_inc(wait_cnt);
  end

  // ---- response stage: one-cycle strobe after completion or abort ----
  // Register the response so it appears in the IDLE cycle after ACCESS ends.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= xfer_done || xfer_abort;
      rsp_err   <= (xfer_done && sel_err) || xfer_abort;
      rsp_rdata <= rsp_data_sel(xfer_done, PWRITE, sel_err, sel_rdata);
    end
  end

endmodule

// File: tb/tb_apb_bridge_n.sv
// Testbench for apb_bridge_n: 4 slaves, 10-bit address, timeout of 4 wait
// states. Each request carries a slave behaviour plan (wait states, error,
// read data); expected responses are queued at accept time and checked by an
// independent monitor, while a slave responder checks the APB phases.
module tb_apb_bridge_n;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int NS = 4;
  localparam int TO = 4;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            waits;
    logic          e;
    logic [DW-1:0] rd;
  } xfer_t;

  typedef struct {
    int            cyc;
    logic          e;
    logic [DW-1:0] rd;
  } rsp_t;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [NS-1:0] PSEL;
  logic PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [NS*DW-1:0] PRDATA = '0;
  logic [NS-1:0] PREADY = '0;
  logic [NS-1:0] PSLVERR = '0;

  apb_bridge_n #(.DATA_W(DW), .ADDR_W(AW), .NUM_SLV(NS), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;
  rsp_t  exp_q[$];
  xfer_t plan_q[$];
  int prev_acc = 0;
  int prev_lat = 0;
  bit drop_xfer = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Number of cycles PENABLE should stay high for a plan.
  function automatic int access_len(input int waits);
    return (waits <= TO) ? waits + 1 : TO + 1;
  endfunction

  function automatic logic [NS-1:0] onehot(input int s);
    logic [NS-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Present one request; record the expected response once it is accepted.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic e, input logic [DW-1:0] rd,
                      input bit b2b);
    xfer_t x;
    rsp_t  r;
    bit    ok;
    int    len;
    x.w = w; x.a = a; x.d = d; x.waits = waits; x.e = e; x.rd = rd;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    ok = 0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge PCLK);
      if (req_ready === 1'b1) begin
        ok = 1;
        len = access_len(waits);
        if (b2b) chk("b2b_accept_cycle", cyc, prev_acc + prev_lat);
        r.cyc = cyc + 2 + len;
        r.e   = (waits > TO) ? 1'b1 : e;
        r.rd  = (!w && !r.e) ? rd : '0;
        exp_q.push_back(r);
        plan_q.push_back(x);
        prev_acc = cyc;
        prev_lat = 2 + len;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(posedge PCLK);
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge PCLK);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
  endtask

  // Slave responder: drives noise on unselected slaves, follows the plan on
  // the selected one, and checks the SETUP/ACCESS phases.
  xfer_t cur;
  bit    active = 0;
  int    acnt = 0;
  int    s = 0;
  bit    rdy;
  always @(negedge PCLK) begin
    PREADY  = NS'($urandom);
    PSLVERR = NS'($urandom);
    PRDATA  = (NS*DW)'($urandom);
    if (PSEL == '0) begin
      if (active && !drop_xfer) chk("penable_len", acnt, access_len(cur.waits));
      active = 0;
    end else if (!PENABLE) begin
      if (plan_q.size() == 0) begin
        chk("setup_unplanned", 1, 0);
      end else begin
        cur = plan_q.pop_front();
        active = 1;
        acnt = 0;
        s = int'(cur.a[AW-1 -: 2]);
        chk("setup_psel", PSEL, onehot(s));
        chk("setup_paddr", PADDR, cur.a);
        chk("setup_pwrite", PWRITE, cur.w);
        chk("setup_pwdata", PWDATA, cur.d);
        PREADY[s] = 1'b0;
      end
    end else if (active) begin
      acnt++;
      chk("access_psel", PSEL, onehot(s));
      chk("access_paddr", PADDR, cur.a);
      chk("access_pwrite", PWRITE, cur.w);
      chk("access_pwdata", PWDATA, cur.d);
      rdy = (acnt == cur.waits + 1);
      PREADY[s] = rdy;
      if (rdy) begin
        PSLVERR[s] = cur.e;
        PRDATA[s*DW +: DW] = cur.rd;
      end
    end
  end

  // Response monitor: pops the oldest expectation on each strobe.
  rsp_t m;
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          m = exp_q.pop_front();
          chk("rsp_cycle", cyc, m.cyc);
          chk("rsp_err", rsp_err, m.e);
          chk("rsp_rdata", rsp_rdata, m.rd);
          chk("rsp_psel_idle", {PENABLE, PSEL}, 0);
        end
      end else begin
        chk("rsp_quiet", {rsp_err, rsp_rdata}, 0);
      end
    end
  end

  logic          w, e;
  logic [AW-1:0] a;
  logic [DW-1:0] d, rd;
  int            waits, gap;
  bit            nxt_b2b;
  rsp_t          dropped;

  initial begin
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk_reset_outputs();
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;

    // Directed transfers, mostly back-to-back.
    send(1'b1, 10'h105, 8'hA5, 0, 1'b0, 8'h00, 0);
    send(1'b0, 10'h012, 8'h00, 3, 1'b0, 8'h3C, 1);
    send(1'b0, 10'h1F0, 8'h00, 0, 1'b1, 8'hFF, 1);
    send(1'b0, 10'h2AA, 8'h00, 7, 1'b0, 8'h55, 1);
    send(1'b1, 10'h333, 8'h77, 0, 1'b0, 8'h00, 1);
    send(1'b0, 10'h000, 8'h00, 0, 1'b0, 8'h11, 1);
    send(1'b0, 10'h100, 8'h00, 0, 1'b0, 8'h22, 1);
    send(1'b0, 10'h200, 8'h00, 0, 1'b0, 8'h44, 1);
    send(1'b0, 10'h300, 8'h00, 0, 1'b0, 8'h88, 1);
    send(1'b0, 10'h3FF, 8'h00, TO, 1'b0, 8'h5A, 1);
    drain();

    // Reset in the middle of ACCESS drops the transfer silently.
    send(1'b0, 10'h3C4, 8'h00, 3, 1'b0, 8'h99, 0);
    for (int n = 0; n < 10 && PENABLE !== 1'b1; n++) @(negedge PCLK);
    chk("rst_in_access", PENABLE, 1);
    #1;
    PRESET = 1'b1;
    drop_xfer = 1;
    if (exp_q.size() > 0) dropped = exp_q.pop_back();
    @(negedge PCLK);
    chk_reset_outputs();
    #1;
    PRESET = 1'b0;
    repeat (8) @(posedge PCLK);
    #1;
    drop_xfer = 0;
    send(1'b0, 10'h0F0, 8'h00, 1, 1'b0, 8'hC3, 0);
    drain();

    // Randomised traffic with random gaps, wait states, errors and timeouts.
    nxt_b2b = 0;
    for (int i = 0; i < 80; i++) begin
      w     = 1'($urandom);
      a     = AW'($urandom);
      d     = DW'($urandom);
      rd    = DW'($urandom);
      waits = $urandom_range(0, 6);
      e     = ($urandom_range(0, 3) == 0);
      send(w, a, d, waits, e, rd, nxt_b2b);
      gap = $urandom_range(0, 2);
      nxt_b2b = (gap == 0);
      if (gap > 0) begin
        repeat (gap) @(posedge PCLK);
        #1;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
